// File: rtl/add_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : add_pipe_if
//  Purpose  : Operand/result streaming bundle for add_pipe (valid/ready both ways).
//             Optional macro ADD_PIPE_OVF_EN adds the out_ovf signal.
//  Revision : 1.0  initial release
// ============================================================================
interface add_pipe_if #(
   parameter int N = 32
);
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  in_a;
   logic [N-1:0]  in_b;
   logic          in_cin;
   logic          in_sub;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  out_sum;
   logic          out_carry;
`ifdef ADD_PIPE_OVF_EN
   logic          out_ovf;
`endif

   modport master (
      output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
`ifdef ADD_PIPE_OVF_EN
      input  out_ovf,
`endif
      input  in_ready, out_valid, out_sum, out_carry
   );

   modport slave (
      input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
`ifdef ADD_PIPE_OVF_EN
      output out_ovf,
`endif
      output in_ready, out_valid, out_sum, out_carry
   );
endinterface
`default_nettype wire

// File: rtl/add_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : add_pipe
//  Purpose  : Pipelined N-bit add/sub, one W-bit carry segment per stage, with
//             global-stall valid/ready flow control. Macro ADD_PIPE_OVF_EN adds out_ovf.
//  Revision : 1.0  initial release
// ============================================================================
module add_pipe #(
   parameter int N      = 32,
   parameter int STAGES = 4
) (
   input  wire logic  clk,
   input  wire logic  nreset,
   add_pipe_if.slave  bus
);
   localparam int W = N / STAGES;

   logic              w_stall;
   logic [STAGES:0]   r_v;
   logic [N-1:0]      r_x [0:STAGES];
   logic [N-1:0]      r_b [0:STAGES-1];
   logic [STAGES:0]   r_c;
   logic [W-1:0]      w_seg [1:STAGES];
   logic [STAGES:1]   w_c;

   assign w_stall      = r_v[STAGES] & ~bus.out_ready;
   assign bus.in_ready = ~w_stall;

   // r_x holds finished sum segments below the current stage and the a operand above it.
   always_comb begin
      w_c = '0;
      for (int k = 1; k <= STAGES; k++) begin
         {w_c[k], w_seg[k]} = {1'b0, r_x[k-1][(k-1)*W +: W]}
                            + {1'b0, r_b[k-1][(k-1)*W +: W]}
                            + {{W{1'b0}}, r_c[k-1]};
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_v <= '0;
      end else if (!w_stall) begin
         r_v <= {r_v[STAGES-1:0], bus.in_valid};
      end
   end

   // Subtraction is folded in at capture: b inverted and carry-in inverted.
   always_ff @(posedge clk) begin
      if (!w_stall) begin
         r_x[0] <= bus.in_a;
         r_b[0] <= bus.in_sub ? ~bus.in_b : bus.in_b;
         r_c[0] <= bus.in_cin ^ bus.in_sub;
         for (int k = 1; k <= STAGES; k++) begin
            r_x[k]                <= r_x[k-1];
            r_x[k][(k-1)*W +: W]  <= w_seg[k];
            r_c[k]                <= w_c[k];
         end
         for (int k = 1; k < STAGES; k++) begin
            r_b[k] <= r_b[k-1];
         end
      end
   end

   assign bus.out_valid = r_v[STAGES];
   assign bus.out_sum   = r_v[STAGES] ? r_x[STAGES] : '0;
   assign bus.out_carry = r_v[STAGES] & r_c[STAGES];

`ifdef ADD_PIPE_OVF_EN
   logic r_ovf;
   logic w_ovf;

   // Operand MSBs are still intact in the last stage's inputs, so overflow is formed there.
   assign w_ovf = (r_x[STAGES-1][N-1] == r_b[STAGES-1][N-1])
                & (w_seg[STAGES][W-1] != r_x[STAGES-1][N-1]);

   always_ff @(posedge clk) begin
      if (!w_stall) begin
         r_ovf <= w_ovf;
      end
   end

   assign bus.out_ovf = r_v[STAGES] & r_ovf;
`endif
endmodule
`default_nettype wire

// File: tb/tb_add_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_add_pipe
//  Purpose  : Directed self-checking bench for add_pipe (N=32, STAGES=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_add_pipe;
   localparam int N      = 32;
   localparam int STAGES = 4;

   logic clk    = 1'b0;
   logic nreset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   add_pipe_if #(.N(N)) bus ();

   add_pipe #(.N(N), .STAGES(STAGES)) dut (
      .clk    (clk),
      .nreset (nreset),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one transaction and measures edges (accept edge = 1) until out_valid.
   task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub,
                          input logic [31:0] es, input logic ec);
      int lat;
      bus.in_a = a; bus.in_b = b; bus.in_cin = cin; bus.in_sub = sub;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      #1;
      chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
      lat = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         bus.in_valid = 1'b0;
         if (bus.out_valid) begin
            lat = i;
            break;
         end
      end
      chk({tag, "_latency"}, 64'(lat), 64'd5);
      chk({tag, "_sum"},     64'(bus.out_sum), 64'(es));
      chk({tag, "_carry"},   64'(bus.out_carry), 64'(ec));
      tick();
   endtask

   logic [31:0] sa [8];
   logic [31:0] sb [8];
   logic        sc [8];
   logic        ss [8];
   logic [31:0] es [8];
   logic        ec [8];

   initial begin
      logic [32:0] t;
      logic [31:0] held;
      int si, ri, stall_left;
      bit leak;

      bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
      bus.in_cin = 1'b0; bus.in_sub = 1'b0; bus.out_ready = 1'b1;

      // Reset state
      tick(); tick();
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_sum",   64'(bus.out_sum),   64'd0);
      chk("rst_out_carry", 64'(bus.out_carry), 64'd0);
      chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
      nreset = 1'b1;
      tick();

      run_one("add_ffff",  32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0);
      run_one("add_ripple",32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1);
      run_one("sub_5_7",   32'd5,        32'd7,        1'b0, 1'b1, 32'hFFFFFFFE, 1'b0);
      run_one("sub_7_5",   32'd7,        32'd5,        1'b1, 1'b1, 32'h00000001, 1'b1);
`ifdef ADD_PIPE_OVF_EN
      bus.in_a = 32'h7FFFFFFF; bus.in_b = 32'd1; bus.in_cin = 1'b0; bus.in_sub = 1'b0;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 10 && !bus.out_valid; i++) tick();
      chk("ovf_sum",   64'(bus.out_sum),   64'h80000000);
      chk("ovf_flag",  64'(bus.out_ovf),   64'd1);
      chk("ovf_carry", 64'(bus.out_carry), 64'd0);
      tick();
      chk("ovf_idle", 64'(bus.out_ovf), 64'd0);
`endif

      // Streaming with a 6-cycle output stall from the first result
      for (int i = 0; i < 8; i++) begin
         sa[i] = $urandom; sb[i] = $urandom;
         sc[i] = 1'($urandom_range(0, 1)); ss[i] = 1'($urandom_range(0, 1));
         if (ss[i]) begin
            t = {1'b0, sa[i]} - {1'b0, sb[i]} - 33'(sc[i]);
            ec[i] = ~t[32];
         end else begin
            t = {1'b0, sa[i]} + {1'b0, sb[i]} + 33'(sc[i]);
            ec[i] = t[32];
         end
         es[i] = t[31:0];
      end
      si = 0; ri = 0; stall_left = -1; held = '0;
      for (int cyc = 0; cyc < 100 && ri < 8; cyc++) begin
         bus.in_valid = (si < 8);
         if (si < 8) begin
            bus.in_a = sa[si]; bus.in_b = sb[si]; bus.in_cin = sc[si]; bus.in_sub = ss[si];
         end
         if (stall_left < 0 && bus.out_valid) begin
            stall_left = 6;
            held = bus.out_sum;
         end
         bus.out_ready = !(stall_left > 0);
         #1;
         if (stall_left > 0) begin
            chk("stall_in_ready", 64'(bus.in_ready),  64'd0);
            chk("stall_hold_sum", 64'(bus.out_sum),   64'(held));
            chk("stall_hold_vld", 64'(bus.out_valid), 64'd1);
            stall_left--;
         end
         if (bus.in_valid && bus.in_ready) si++;
         if (bus.out_valid && bus.out_ready) begin
            chk($sformatf("stream_sum%0d", ri),   64'(bus.out_sum),   64'(es[ri]));
            chk($sformatf("stream_carry%0d", ri), 64'(bus.out_carry), 64'(ec[ri]));
            ri++;
         end
         tick();
      end
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      chk("stream_count", 64'(ri), 64'd8);
      tick();
      chk("stream_no_dup", 64'(bus.out_valid), 64'd0);

      // Asynchronous reset with three transactions in flight
      for (int i = 0; i < 3; i++) begin
         bus.in_a = 32'(i + 10); bus.in_b = 32'(i); bus.in_cin = 1'b0; bus.in_sub = 1'b0;
         bus.in_valid = 1'b1;
         tick();
      end
      bus.in_valid = 1'b0;
      nreset = 1'b0;
      #1;
      chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("arst_out_sum",   64'(bus.out_sum),   64'd0);
      chk("arst_in_ready",  64'(bus.in_ready),  64'd1);
      tick();
      nreset = 1'b1;
      leak = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.out_valid) leak = 1'b1;
      end
      chk("arst_no_partial", 64'(leak), 64'd0);
      run_one("post_rst", 32'd1, 32'd2, 1'b0, 1'b0, 32'd3, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/add_pipe.md
Name: add_pipe

Overview:
- Parametrised, pipelined N-bit adder/subtractor with valid/ready streaming handshake and per-transaction add/sub mode.
- Carry chain is split into STAGES segments, one segment per pipeline stage, so wide adders close timing.
- Successor to the team's fixed two-stage registered adder.
- Sits in datapaths as a drop-in arithmetic stage between streaming producers and consumers.

Parameters:
- N, 32, operand/result width in bits; N % STAGES must equal 0.
- STAGES, 4, number of carry segments and adder pipeline stages; range 1..N. Segment width W = N/STAGES.

Ports:
- clk  input  1  clock; all state updates on posedge.
- nreset  input  1  asynchronous active-low reset.
- in_valid  input  1  input transaction valid.
- in_ready  output  1  block can accept input this cycle.
- in_a  input  N  first operand.
- in_b  input  N  second operand.
- in_cin  input  1  carry-in (add) / borrow-in (sub).
- in_sub  input  1  0: add, 1: subtract.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  N  result.
- out_carry  output  1  raw carry out of bit N-1 (sub: 1 = no borrow).

Behaviour:
- Arithmetic, all modulo 2^N:
  - add: {out_carry,out_sum} = in_a + in_b + in_cin.
  - sub: {out_carry,out_sum} = in_a + ~in_b + !in_cin, i.e. a - b - cin.
- Input handshake: a transfer occurs when in_valid & in_ready at posedge. Operands, cin and mode are captured into the input register (stage 0).
- Pipeline:
  - Stage k (1..STAGES) adds segment k-1 (bits [(k-1)*W +: W]) using the carry registered by stage k-1.
  - Completed lower segments and not-yet-used upper operand segments are carried forward in registers.
  - Stage STAGES drives out_sum/out_carry/out_valid from registers; no combinational path from in_a/in_b to outputs.
- Latency: STAGES+1 cycles from the accepting edge to out_valid high, with out_ready held high.
- Throughput: one transaction per cycle.
- Flow control:
  - Global stall: stall = out_valid & ~out_ready. While stalled, every stage register, including valid bits, holds.
  - in_ready = ~stall, a combinational path from out_ready and permitted.
  - Bubbles are not collapsed.
  - Output transfer occurs when out_valid & out_ready.
- Output stability: while out_valid=1 and out_ready=0, out_sum/out_carry/out_valid stay unchanged.
- Data-path regs of invalid stages are don't-care, but out_sum/out_carry must read 0 whenever out_valid=0 (gated at output).
- Reset:
  - nreset low clears all valid bits immediately (asynchronous); out_valid=0, out_sum=0, out_carry=0.
  - in_ready is 1 during and after reset.
  - Transactions in flight at reset are discarded; no partial result is ever presented.
  - Data-path registers need not be reset.
- STAGES=1: single adder stage, latency 2 (matches the legacy block).
- Simultaneous input and output transfer in the same cycle is legal and loses nothing.

Optional Feature:
- Macro: ADD_PIPE_OVF_EN.
- Defined: adds port out_ovf output 1, the two's-complement signed overflow of the operation.
  - Computed from the operand MSBs and the result MSB (b MSB inverted for sub).
  - Pipelined alongside out_sum, with the same latency and stall behaviour.
  - Reads 0 when out_valid=0 and 0 after reset.
- Undefined: port absent, no extra logic.

Test Plan (N=32, STAGES=4):
- Add 0x0000FFFF + 0x00000001, cin=0 → out_sum=0x00010000, out_carry=0, out_valid exactly 5 cycles after accept.
- Add 0xFFFFFFFF + 0x00000000, cin=1 → out_sum=0x00000000, out_carry=1 (carry ripples through all 4 stages).
- Sub 5 - 7, cin=0 → out_sum=0xFFFFFFFE, out_carry=0.
- Sub 7 - 5, cin=1 → out_sum=0x00000001, out_carry=1.
- Stream 8 back-to-back random transactions; hold out_ready=0 from the first result for 6 cycles → in_ready=0 while stalled, out_sum stable. After release, all 8 results emerge in order with no loss or duplication; compare against the golden model.
- Assert nreset low for 1 cycle with 3 transactions in flight → out_valid=0 immediately, out_sum=0, in_ready=1. A subsequent transaction 1+2 yields 3 after 5 cycles.
- With ADD_PIPE_OVF_EN, add 0x7FFFFFFF + 1 → out_sum=0x80000000, out_ovf=1, out_carry=0.
